sfp_std2slf_pipe: RTL and testbench

SFP_STD2SLF_PIPE -- requirements
Module: sfp_std2slf_pipe

---
 rtl/sfp_std2slf_pipe.sv | 141 ++++++++++++++
 tb/tb_sfp_std2slf_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_std2slf_pipe.sv
// IEEE754 single -> {sign, true exponent, two's-complement mantissa}, two-stage pipeline.
// Define SFP_STD2SLF_FLAG_EN to add the {nan, ovf} status output o_flg.
`timescale 1ns / 1ps
module sfp_std2slf_pipe #(
    parameter int unsigned MW = 17
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic [31:0]   i_dat,
    output logic          o_vld,
    input  logic          i_rdy,
    output logic [MW+8:0] o_dat
`ifdef SFP_STD2SLF_FLAG_EN
    ,
    output logic [1:0]    o_flg
`endif
);

    localparam int unsigned    Drop    = 25 - MW;
    localparam logic [24:0]    RemMask = 25'((1 << Drop) - 1);
    localparam logic [24:0]    Half    = 25'((1 << Drop) >> 1);
    localparam logic [MW-1:0]  MagMax  = {1'b0, {(MW-1){1'b1}}};

    logic en1, en2;
    logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;

    assign en2   = !s2_vld_q || i_rdy;
    assign en1   = !s1_vld_q || en2;
    assign o_rdy = en1;

    // S1: unpack, classify, round to MW-1 magnitude bits
    logic [7:0]        exp_field;
    logic [22:0]       frac;
    logic [24:0]       mag25, rem25;
    logic [MW-1:0]     keep;
    logic              round_up;
    logic              s1_sign_d, s1_spec_d;
    logic signed [9:0] s1_exp_d;
    logic [MW-1:0]     s1_mag_d;

    always_comb begin
        exp_field = i_dat[30:23];
        frac      = i_dat[22:0];
        mag25     = {1'b0, |exp_field, frac};
        keep      = MW'(mag25 >> Drop);
        rem25     = mag25 & RemMask;
        round_up  = (rem25 > Half) || ((rem25 == Half) && (Half != 25'd0) && keep[0]);
        s1_mag_d  = keep + MW'(round_up);
        if (exp_field != 8'd0) begin
            s1_exp_d = $signed({2'b00, exp_field}) - 10'sd127;
        end else if (frac != 23'd0) begin
            s1_exp_d = -10'sd126;
        end else begin
            s1_exp_d = -10'sd127;
        end
        s1_spec_d = &exp_field;
        s1_sign_d = i_dat[31];
    end

    logic              s1_sign_q, s1_spec_q;
    logic signed [9:0] s1_exp_q;
    logic [MW-1:0]     s1_mag_q;

    always_ff @(posedge i_clk) begin
        if (en1 && i_vld) begin
            s1_sign_q <= s1_sign_d;
            s1_spec_q <= s1_spec_d;
            s1_exp_q  <= s1_exp_d;
            s1_mag_q  <= s1_mag_d;
        end
    end

    // S2: renormalise after rounding carry, saturate, negate
    logic              carry, ovf, sat;
    logic signed [9:0] exp_rn;
    logic [MW-1:0]     mag_rn, mag_o, mant_o;
    logic [7:0]        exp_o;
    logic [MW+8:0]     s2_dat_d, s2_dat_q;

    always_comb begin
        carry    = s1_mag_q[MW-1];
        exp_rn   = s1_exp_q + $signed({9'd0, carry});
        mag_rn   = carry ? (s1_mag_q >> 1) : s1_mag_q;
        ovf      = !s1_spec_q && (exp_rn > 10'sd127);
        sat      = s1_spec_q || ovf;
        exp_o    = sat ? 8'h7F : exp_rn[7:0];
        mag_o    = sat ? MagMax : mag_rn;
        mant_o   = s1_sign_q ? -mag_o : mag_o;
        s2_dat_d = {s1_sign_q, exp_o, mant_o};
    end

    always_comb begin
        s1_vld_d = en1 ? i_vld : s1_vld_q;
        s2_vld_d = en2 ? s1_vld_q : s2_vld_q;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (en2 && s1_vld_q) begin
            s2_dat_q <= s2_dat_d;
        end
    end

    assign o_vld = s2_vld_q;
    assign o_dat = s2_dat_q;

`ifdef SFP_STD2SLF_FLAG_EN
    logic       s1_nan_q;
    logic [1:0] s2_flg_q, s2_flg_d;

    always_ff @(posedge i_clk) begin
        if (en1 && i_vld) begin
            s1_nan_q <= s1_spec_d && (frac != 23'd0);
        end
    end

    assign s2_flg_d = {s1_nan_q, sat && !s1_nan_q};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s2_flg_q <= 2'b00;
        end else if (en2 && s1_vld_q) begin
            s2_flg_q <= s2_flg_d;
        end
    end

    assign o_flg = s2_flg_q;
`endif

endmodule

// File: tb/tb_sfp_std2slf_pipe.sv
// Self-checking bench for sfp_std2slf_pipe (MW=17): real-arithmetic model + scoreboard,
// pinned by hand-computed vectors; flag checks active when SFP_STD2SLF_FLAG_EN is defined.
`timescale 1ns / 1ps
module tb_sfp_std2slf_pipe;

    localparam int MW = 17;
    localparam int DW = MW + 9;
    localparam int NV = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld, in_rdy, out_vld, out_rdy;
    logic [31:0]   in_dat;
    logic [DW-1:0] out_dat;
`ifdef SFP_STD2SLF_FLAG_EN
    logic [1:0]    out_flg;
`endif

    sfp_std2slf_pipe #(.MW(MW)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .i_vld (in_vld),
        .o_rdy (in_rdy),
        .i_dat (in_dat),
        .o_vld (out_vld),
        .i_rdy (out_rdy),
        .o_dat (out_dat)
`ifdef SFP_STD2SLF_FLAG_EN
        ,
        .o_flg (out_flg)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Hand-computed vectors; flags are {nan, ovf}
    logic [31:0]   vin  [NV] = '{32'h3F800000, 32'hBF800000, 32'h3FFFFFFF, 32'h3F808000,
                                 32'h3F800080, 32'h3F800180, 32'h7F800000, 32'hFFC00000,
                                 32'h00000000, 32'h00000001, 32'h007FFFFF, 32'h7F7FFFFF,
                                 32'h80000000, 32'hC0490FDB, 32'h3E000000};
    logic [DW-1:0] vout [NV] = '{{1'b0, 8'h00, 17'h08000}, {1'b1, 8'h00, 17'h18000},
                                 {1'b0, 8'h01, 17'h08000}, {1'b0, 8'h00, 17'h08080},
                                 {1'b0, 8'h00, 17'h08000}, {1'b0, 8'h00, 17'h08002},
                                 {1'b0, 8'h7F, 17'h0FFFF}, {1'b1, 8'h7F, 17'h10001},
                                 {1'b0, 8'h81, 17'h00000}, {1'b0, 8'h82, 17'h00000},
                                 {1'b0, 8'h82, 17'h08000}, {1'b0, 8'h7F, 17'h0FFFF},
                                 {1'b1, 8'h81, 17'h00000}, {1'b1, 8'h01, 17'h136F0},
                                 {1'b0, 8'hFD, 17'h08000}};
    logic [1:0]    vflg [NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10,
                                 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};

    // Value-level model: significand scaled to MW-2 fraction bits, rounded half-to-even in reals
    function automatic void model(input logic [31:0] w, output logic [DW-1:0] dat,
                                  output logic [1:0] flg);
        int            e;
        longint        r;
        real           sig, x, f;
        logic [7:0]    ef;
        logic [22:0]   fr;
        logic [MW-1:0] mant;
        logic [7:0]    e8;
        ef  = w[30:23];
        fr  = w[22:0];
        flg = 2'b00;
        if (ef == 8'hFF) begin
            e   = 127;
            r   = (longint'(1) << (MW - 1)) - 1;
            flg = (fr != 23'd0) ? 2'b10 : 2'b01;
        end else begin
            if (ef == 8'd0) e = (fr == 23'd0) ? -127 : -126;
            else            e = int'(ef) - 127;
            sig = ((ef == 8'd0) ? 0.0 : 1.0) + real'(fr) / 8388608.0;
            x   = sig * real'(longint'(1) << (MW - 2));
            f   = $floor(x);
            r   = longint'(f);
            if ((x - f) > 0.5 || ((x - f) == 0.5 && (r % 2) == 1)) r++;
            if (r == (longint'(1) << (MW - 1))) begin
                r = r / 2;
                e++;
            end
            if (e > 127) begin
                e   = 127;
                r   = (longint'(1) << (MW - 1)) - 1;
                flg = 2'b01;
            end
        end
        mant = MW'(r);
        if (w[31]) mant = -mant;
        e8  = 8'(e);
        dat = {w[31], e8, mant};
    endfunction

    typedef struct {
        logic [DW-1:0] dat;
        logic [1:0]    flg;
        logic          lit;
        logic [DW-1:0] ldat;
        logic [1:0]    lflg;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          ent;
    logic          lit_on;
    logic [DW-1:0] lit_dat;
    logic [1:0]    lit_flg;
    int            occ = 0;
    logic          held = 1'b0;
    logic [DW-1:0] held_dat;
    logic [DW-1:0] m_dat;
    logic [1:0]    m_flg;

    // Mid-cycle compare: inputs only change just after the rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            occ  = 0;
            held = 1'b0;
        end else begin
            check("o_rdy", in_rdy, !(occ == 2 && !out_rdy));
            if (occ == 0) check("o_vld_idle", out_vld, 1'b0);
            if (held) begin
                check("hold_vld", out_vld, 1'b1);
                check("hold_dat", out_dat, held_dat);
            end
            if (out_vld && out_rdy) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_vld, 1'b0);
                end else begin
                    ent = exp_q.pop_front();
                    check("dat", out_dat, ent.dat);
                    if (ent.lit) check("dat_lit", out_dat, ent.ldat);
`ifdef SFP_STD2SLF_FLAG_EN
                    check("flg", out_flg, ent.flg);
                    if (ent.lit) check("flg_lit", out_flg, ent.lflg);
`endif
                end
            end
            if (in_vld && in_rdy) begin
                model(in_dat, m_dat, m_flg);
                if (lit_on) begin
                    check("model_pin_dat", m_dat, lit_dat);
                    check("model_pin_flg", m_flg, lit_flg);
                end
                exp_q.push_back('{dat: m_dat, flg: m_flg, lit: lit_on, ldat: lit_dat,
                                  lflg: lit_flg});
            end
            occ      = occ + int'(in_vld && in_rdy) - int'(out_vld && out_rdy);
            held     = out_vld && !out_rdy;
            held_dat = out_dat;
        end
    end

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic stream8();
        int   idx = 0;
        int   c   = 0;
        int   n0  = n_out;
        logic acc;
        logic saw = 1'b0;
        while (idx < 8 && c < 40) begin
            out_rdy = !(c >= 3 && c <= 6);
            in_vld  = 1'b1;
            in_dat  = vin[idx];
            lit_on  = 1'b1;
            lit_dat = vout[idx];
            lit_flg = vflg[idx];
            @(negedge clk);
            acc = in_rdy;
            if (!in_rdy) saw = 1'b1;
            @(posedge clk);
            #1;
            if (acc) idx++;
            c++;
        end
        in_vld  = 1'b0;
        lit_on  = 1'b0;
        out_rdy = 1'b1;
        check("stall_o_rdy_low", saw, 1'b1);
        check("stream_accepted", idx, 8);
        drain("stream_drain");
        check("stream_out_count", n_out - n0, 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n0;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_dat  = '0;
        out_rdy = 1'b1;
        lit_on  = 1'b0;
        lit_dat = '0;
        lit_flg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_o_vld", out_vld, 1'b0);
        check("rst_o_rdy", in_rdy, 1'b1);
`ifdef SFP_STD2SLF_FLAG_EN
        check("rst_o_flg", out_flg, 2'b00);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: accepted at edge k, visible after edge k+1
        in_vld  = 1'b1;
        in_dat  = vin[0];
        lit_on  = 1'b1;
        lit_dat = vout[0];
        lit_flg = vflg[0];
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        lit_on = 1'b0;
        check("lat_vld_1", out_vld, 1'b0);
        @(posedge clk);
        #1;
        check("lat_vld_2", out_vld, 1'b1);
        check("lat_dat_2", out_dat, vout[0]);
        drain("lat_drain");

        // Back-to-back directed vectors
        for (int i = 0; i < NV; i++) begin
            in_vld  = 1'b1;
            in_dat  = vin[i];
            lit_on  = 1'b1;
            lit_dat = vout[i];
            lit_flg = vflg[i];
            @(posedge clk);
            #1;
        end
        in_vld = 1'b0;
        lit_on = 1'b0;
        drain("vec_drain");

        stream8();

        // Reset with two words in flight
        for (int i = 0; i < 2; i++) begin
            in_vld = 1'b1;
            in_dat = vin[i];
            @(posedge clk);
            #1;
        end
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_o_vld", out_vld, 1'b0);
        check("midrst_o_rdy", in_rdy, 1'b1);
`ifdef SFP_STD2SLF_FLAG_EN
        check("midrst_o_flg", out_flg, 2'b00);
`endif
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        n0      = n_out;
        repeat (6) @(posedge clk);
        #1;
        check("postrst_o_vld", out_vld, 1'b0);
        check("postrst_no_stale", n_out - n0, 0);

        // Still functional after reset
        in_vld  = 1'b1;
        in_dat  = vin[13];
        lit_on  = 1'b1;
        lit_dat = vout[13];
        lit_flg = vflg[13];
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        lit_on = 1'b0;
        drain("postrst_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
